// File: rtl/button_event.sv
// Button-event decoder: turns a debounced button level into press/release pulses,
// held and long-press levels, plus auto-repeat pulses when BUTTON_REPEAT_EN is defined.
module button_event #(
    parameter int unsigned HOLD_CYCLES   = 24'd5000000,
    parameter int unsigned REPEAT_CYCLES = 24'd2500000,
    parameter int unsigned CNT_W         = 24
) (
    input  logic clk,
    input  logic rst_n,
    input  logic button_in,
    output logic press_pulse,
    output logic release_pulse,
    output logic held,
    output logic long_press,
    output logic repeat_pulse
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PRESSED = 2'd1,
        LONG    = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
`ifdef BUTTON_REPEAT_EN
    localparam logic [CNT_W-1:0] REPEAT_LAST = CNT_W'(REPEAT_CYCLES - 1);
`endif

    // Thresholds below 2 would make the pulse and level outputs overlap ambiguously.
    generate
        if (HOLD_CYCLES < 2 || REPEAT_CYCLES < 2) begin : g_bad_params
            $error("button_event: HOLD_CYCLES and REPEAT_CYCLES must be >= 2");
        end
    endgenerate

    state_t           state_reg, state_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic             btn_q_reg;
    logic             press_reg, press_next;
    logic             release_reg, release_next;
    logic             long_reg, long_next;
    logic             repeat_reg, repeat_next;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg   <= IDLE;
            cnt_reg     <= '0;
            btn_q_reg   <= 1'b0;
            press_reg   <= 1'b0;
            release_reg <= 1'b0;
            long_reg    <= 1'b0;
            repeat_reg  <= 1'b0;
        end else begin
            state_reg   <= state_next;
            cnt_reg     <= cnt_next;
            btn_q_reg   <= button_in;
            press_reg   <= press_next;
            release_reg <= release_next;
            long_reg    <= long_next;
            repeat_reg  <= repeat_next;
        end
    end

    // Release is tested first in every held state so it beats threshold and repeat expiry.
    always_comb begin
        state_next   = state_reg;
        cnt_next     = cnt_reg;
        press_next   = 1'b0;
        release_next = 1'b0;
        long_next    = long_reg;
        repeat_next  = 1'b0;
        case (state_reg)
            IDLE: begin
                if (button_in) begin
                    state_next = PRESSED;
                    cnt_next   = '0;
                    press_next = 1'b1;
                end
            end
            PRESSED: begin
                if (!button_in) begin
                    state_next   = IDLE;
                    release_next = 1'b1;
                end else if (cnt_reg == HOLD_LAST) begin
                    state_next = LONG;
                    long_next  = 1'b1;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end
            LONG: begin
                if (!button_in) begin
                    state_next   = IDLE;
                    release_next = 1'b1;
                    long_next    = 1'b0;
                end else begin
`ifdef BUTTON_REPEAT_EN
                    if (cnt_reg == REPEAT_LAST) begin
                        repeat_next = 1'b1;
                        cnt_next    = '0;
                    end else begin
                        cnt_next = cnt_reg + 1'b1;
                    end
`endif
                end
            end
            default: begin
                state_next = IDLE;
                long_next  = 1'b0;
            end
        endcase
    end

    assign press_pulse   = press_reg;
    assign release_pulse = release_reg;
    assign held          = btn_q_reg;
    assign long_press    = long_reg;
    assign repeat_pulse  = repeat_reg;

endmodule

// File: tb/tb_button_event.sv
// Bench for button_event: run-length reference model checked every falling edge,
// plus literal expectations for each directed scenario.
module tb_button_event;

    localparam int H = 8;
    localparam int R = 4;
`ifdef BUTTON_REPEAT_EN
    localparam bit REP_EN = 1'b1;
`else
    localparam bit REP_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic button_in = 1'b1;
    logic press_pulse, release_pulse, held, long_press, repeat_pulse;

    int checks = 0;
    int errors = 0;

    button_event #(
        .HOLD_CYCLES  (H),
        .REPEAT_CYCLES(R),
        .CNT_W        (24)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .button_in    (button_in),
        .press_pulse  (press_pulse),
        .release_pulse(release_pulse),
        .held         (held),
        .long_press   (long_press),
        .repeat_pulse (repeat_pulse)
    );

    always #5 clk = ~clk;

    // Reference: outputs follow from the length of the current run of high samples.
    int   run;
    logic exp_press, exp_release, exp_held, exp_long, exp_repeat;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run         <= 0;
            exp_press   <= 1'b0;
            exp_release <= 1'b0;
            exp_held    <= 1'b0;
            exp_long    <= 1'b0;
            exp_repeat  <= 1'b0;
        end else begin
            exp_press   <= button_in && (run == 0);
            exp_release <= !button_in && (run > 0);
            exp_held    <= button_in;
            exp_long    <= button_in && (run + 1 >= H + 1);
            exp_repeat  <= REP_EN && button_in && (run + 1 > H + 1) &&
                           (((run + 1 - (H + 1)) % R) == 0);
            run         <= button_in ? run + 1 : 0;
        end
    end

    function automatic void chk(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endfunction

    // Falling-edge observation: model compare plus event tallies for literal checks.
    int ne_cnt = 0;
    int n_press = 0, n_rel = 0, n_rep = 0, n_held = 0, n_long = 0;
    int long_rise_ne = -1;
    logic long_prev = 1'b0;
    always @(negedge clk) begin
        chk("model_press", press_pulse, exp_press);
        chk("model_release", release_pulse, exp_release);
        chk("model_held", held, exp_held);
        chk("model_long", long_press, exp_long);
        chk("model_repeat", repeat_pulse, exp_repeat);
        ne_cnt++;
        n_press += int'(press_pulse);
        n_rel   += int'(release_pulse);
        n_rep   += int'(repeat_pulse);
        n_held  += int'(held);
        n_long  += int'(long_press);
        if (long_press && !long_prev) long_rise_ne = ne_cnt;
        long_prev = long_press;
    end

    task automatic wait_ne(int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    int s_press, s_rel, s_rep, s_held, s_long, s_ne;
    task automatic snap();
        s_press = n_press; s_rel = n_rel; s_rep = n_rep;
        s_held = n_held; s_long = n_long;
    endtask

    initial begin
        // Reset held with button pressed: outputs stay low.
        wait_ne(3);
        chk("rst_press", press_pulse, 0);
        chk("rst_held", held, 0);
        chk("rst_long", long_press, 0);
        chk("rst_release", release_pulse, 0);
        rst_n = 1'b1;
        wait_ne(1);
        $display("reset exit: press_pulse=%0b", press_pulse);
        chk("rst_exit_press", press_pulse, 1);
        wait_ne(1);
        chk("rst_exit_press_clear", press_pulse, 0);
        button_in = 1'b0;
        wait_ne(3);

        // Short press, 3 samples high.
        snap();
        button_in = 1'b1;
        wait_ne(3);
        button_in = 1'b0;
        wait_ne(4);
        $display("short press: press=%0d held=%0d release=%0d long=%0d",
                 n_press - s_press, n_held - s_held, n_rel - s_rel, n_long - s_long);
        chk("short_press_cnt", n_press - s_press, 1);
        chk("short_held_cycles", n_held - s_held, 3);
        chk("short_release_cnt", n_rel - s_rel, 1);
        chk("short_long_cnt", n_long - s_long, 0);

        // Long press, 20 samples high.
        snap();
        s_ne = ne_cnt;
        button_in = 1'b1;
        wait_ne(20);
        button_in = 1'b0;
        wait_ne(4);
        $display("long press: rise_at=%0d long=%0d repeat=%0d release=%0d",
                 long_rise_ne - s_ne, n_long - s_long, n_rep - s_rep, n_rel - s_rel);
        chk("long_rise_offset", long_rise_ne - s_ne, 9);
        chk("long_cycles", n_long - s_long, 12);
        chk("long_repeat_cnt", n_rep - s_rep, REP_EN ? 2 : 0);
        chk("long_release_cnt", n_rel - s_rel, 1);

        // Threshold race: release on the sample where the hold count would expire.
        snap();
        button_in = 1'b1;
        wait_ne(8);
        button_in = 1'b0;
        wait_ne(4);
        $display("threshold race: long=%0d release=%0d", n_long - s_long, n_rel - s_rel);
        chk("race_long_cnt", n_long - s_long, 0);
        chk("race_release_cnt", n_rel - s_rel, 1);

        // Minimum and back-to-back presses.
        snap();
        for (int i = 0; i < 3; i++) begin
            button_in = 1'b1;
            wait_ne(1);
            button_in = 1'b0;
            wait_ne(1);
        end
        wait_ne(2);
        $display("pulse train: press=%0d release=%0d", n_press - s_press, n_rel - s_rel);
        chk("train_press_cnt", n_press - s_press, 3);
        chk("train_release_cnt", n_rel - s_rel, 3);

        // Reset during LONG clears outputs before the next rising edge.
        button_in = 1'b1;
        wait_ne(12);
        chk("midhold_long_before", long_press, 1);
        #2 rst_n = 1'b0;
        #1;
        $display("mid-hold reset: long=%0b held=%0b repeat=%0b",
                 long_press, held, repeat_pulse);
        chk("midhold_long", long_press, 0);
        chk("midhold_held", held, 0);
        chk("midhold_repeat", repeat_pulse, 0);
        wait_ne(2);
        rst_n = 1'b1;
        wait_ne(1);
        chk("midhold_repress", press_pulse, 1);
        button_in = 1'b0;
        wait_ne(3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
